// File: rtl/udp_tx_packer.sv
// Word-stream feeder for the 32-bit UDP transmit engine: buffers input words in a FIFO,
// launches full or flushed-partial packets and answers the engine's word requests.
module udp_tx_packer #(
  parameter int ADDR_W    = 10,
  parameter int PKT_WORDS = 256,
  parameter int FLUSH_CYC = 65535
) (
  input  logic              gmii_tx_clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  input  logic              tx_req,
  output logic [31:0]       tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_level,
  output logic [15:0]       pkt_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 14;
  localparam logic [ADDR_W:0] LVL_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_PKT   = (ADDR_W+1)'(PKT_WORDS);
  localparam logic [ADDR_W:0] LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [15:0] FLUSH_LIM     = (FLUSH_CYC == 0) ? 16'd0 : 16'(FLUSH_CYC - 1);
  localparam bit FLUSH_EN               = (FLUSH_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_SEND
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic [15:0]       idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [15:0]       byte_num_q, byte_num_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [31:0]       tx_data_q;

  logic wr_en;
  logic pop_en;
  logic full_hit;
  logic flush_hit;

  assign in_ready = (level_q != LVL_FULL);
  assign wr_en    = in_valid && in_ready;
  assign pop_en   = (state_q == S_SEND) && tx_req && (remaining_q != '0);

  always_comb begin
    level_d = level_q;
    unique case ({wr_en, pop_en})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Threshold uses the next level so START follows the filling write by one cycle.
  assign full_hit  = (level_d >= LVL_PKT);
  assign flush_hit = FLUSH_EN && (level_q != '0) && (idle_cnt_q == FLUSH_LIM);

  always_comb begin
    state_d     = state_q;
    byte_num_d  = byte_num_q;
    remaining_d = remaining_q;
    pkt_cnt_d   = pkt_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (full_hit) begin
          state_d    = S_START;
          byte_num_d = {CNT_W'(PKT_WORDS), 2'b00};
        end else if (flush_hit) begin
          state_d    = S_START;
          byte_num_d = {CNT_W'(level_q), 2'b00};
        end
      end
      S_START: begin
        remaining_d = byte_num_q[CNT_W+1:2];
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (pop_en) begin
          remaining_d = remaining_q - CNT_W'(1);
        end
        // Unserved words are abandoned here but remain queued in the FIFO.
        if (tx_done) begin
          state_d     = S_IDLE;
          remaining_d = '0;
          pkt_cnt_d   = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q != S_IDLE) || (state_d != S_IDLE) || wr_en || (level_q == '0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != FLUSH_LIM) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      idle_cnt_q  <= '0;
      remaining_q <= '0;
      byte_num_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      idle_cnt_q  <= idle_cnt_d;
      remaining_q <= remaining_d;
      byte_num_q  <= byte_num_d;
      pkt_cnt_q   <= pkt_cnt_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge gmii_tx_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
    end else if (pop_en) begin
      tx_data_q <= mem[rd_ptr_q];
    end
  end

  assign tx_start_en = (state_q == S_START);
  assign busy        = (state_q != S_IDLE);
  assign tx_byte_num = byte_num_q;
  assign tx_data     = tx_data_q;
  assign fifo_level  = level_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_udp_tx_packer.sv
// Scoreboard bench for udp_tx_packer: directed stimulus pushes expected starts/words,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_udp_tx_packer;

  localparam int ADDR_W    = 4;
  localparam int PKT_WORDS = 4;
  localparam int FLUSH_CYC = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              tx_start_en;
  logic [15:0]       tx_byte_num;
  logic              tx_req;
  logic [31:0]       tx_data;
  logic              tx_done;
  logic              busy;
  logic [ADDR_W:0]   fifo_level;
  logic [15:0]       pkt_cnt;

  always #5 clk = ~clk;

  udp_tx_packer #(
    .ADDR_W    (ADDR_W),
    .PKT_WORDS (PKT_WORDS),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .pkt_cnt     (pkt_cnt)
  );

  typedef struct {
    int          cyc;
    logic [15:0] bytes;
  } start_t;

  start_t      start_q[$];
  logic [31:0] data_q[$];
  logic [31:0] model[$];
  logic [31:0] last_exp = 32'h0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          exp_pkt = 0;
  logic        req_seen = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    req_seen <= tx_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one tx_data word per request of the previous cycle, plus start pulses.
  always @(negedge clk) begin
    logic [31:0] e;
    start_t      s;
    if (req_seen) begin
      if (data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_data_unexpected: got 0x%08h expected no word (cycle %0d)", tx_data, cyc);
      end else begin
        e = data_q.pop_front();
        check("tx_data", tx_data, e);
        $display("word  cycle %0d data 0x%08h", cyc, tx_data);
      end
    end
    if (tx_start_en) begin
      if (start_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_unexpected: got start bytes=%0d expected none (cycle %0d)", tx_byte_num, cyc);
      end else begin
        s = start_q.pop_front();
        check("start_cycle", 32'(cyc), 32'(s.cyc));
        check("tx_byte_num", 32'(tx_byte_num), 32'(s.bytes));
        $display("start cycle %0d bytes %0d", cyc, tx_byte_num);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_start(input int c, input int bytes);
    start_t s;
    s.cyc   = c;
    s.bytes = 16'(bytes);
    start_q.push_back(s);
  endtask

  task automatic wr(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    model.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic req(input bit pops);
    if (pops) begin
      last_exp = model.pop_front();
    end
    data_q.push_back(last_exp);
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
  endtask

  task automatic req_wr(input logic [31:0] d);
    last_exp = model.pop_front();
    data_q.push_back(last_exp);
    model.push_back(d);
    tx_req   = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
    step();
    tx_req   = 1'b0;
    in_valid = 1'b0;
    check("level_rw", 32'(fifo_level), 32'(PKT_WORDS));
  endtask

  task automatic finish_pkt(input bit next);
    int t;
    t = cyc;
    if (next) expect_start(t + 2, 4 * PKT_WORDS);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    exp_pkt++;
    check("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
    while (next && cyc < t + 3) step();
  endtask

  task automatic reset_checks();
    check("rst_start", 32'(tx_start_en), 32'h0);
    check("rst_bytes", 32'(tx_byte_num), 32'h0);
    check("rst_data",  tx_data,          32'h0);
    check("rst_busy",  32'(busy),        32'h0);
    check("rst_level", 32'(fifo_level),  32'h0);
    check("rst_pkt",   32'(pkt_cnt),     32'h0);
    check("rst_ready", 32'(in_ready),    32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    tx_req   = 1'b0;
    tx_done  = 1'b0;
    step();
    step();
    reset_checks();
    rst_n = 1'b1;
    step();

    // Full packet, extra request, stray done.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_start(cyc + 1, 16);
      wr(32'h11111111 * (i + 1));
    end
    step();
    check("busy_send", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) req(1'b1);
    req(1'b0);
    check("level_empty", 32'(fifo_level), 32'h0);
    finish_pkt(1'b0);
    check("busy_idle", 32'(busy), 32'h0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("pkt_stray_done", 32'(pkt_cnt), 32'(exp_pkt));

    // Flush with a write at idle cycle 5 restarting the count.
    wr(32'hA0000001);
    wr(32'hA0000002);
    for (int i = 0; i < 4; i++) step();
    s = cyc + FLUSH_CYC + 1;
    expect_start(s, 12);
    wr(32'hA0000003);
    while (cyc < s + 1) step();
    check("busy_flush", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) req(1'b1);
    finish_pkt(1'b0);

    // Backpressure: 20 offers into a 16-deep FIFO with the engine stalled.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hB0000000 + 32'(i);
      check("bp_ready", 32'(in_ready), 32'(i < 16));
      if (i < 16) model.push_back(in_data);
      if (i == 3) expect_start(cyc + 1, 16);
      step();
    end
    in_valid = 1'b0;
    check("bp_level", 32'(fifo_level), 32'd16);
    check("bp_ready_full", 32'(in_ready), 32'h0);
    req(1'b1);
    check("bp_ready_back", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) req(1'b1);
    finish_pkt(1'b1);
    for (int p = 1; p < 4; p++) begin
      for (int i = 0; i < 4; i++) req(1'b1);
      finish_pkt(p < 3);
    end
    check("bp_drained", 32'(fifo_level), 32'h0);

    // Simultaneous read/write across pointer wrap, 12 packets / 48 words.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_start(cyc + 1, 16);
      wr(32'hC0000000 + 32'(i));
    end
    step();
    for (int p = 0; p < 12; p++) begin
      for (int j = 0; j < 4; j++) begin
        if (p < 11) req_wr(32'hC0000004 + 32'(p * 4 + j));
        else        req(1'b1);
      end
      finish_pkt(p < 11);
    end
    check("rw_drained", 32'(fifo_level), 32'h0);

    // Reset in SEND after two of four words, then a fresh packet.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_start(cyc + 1, 16);
      wr(32'hE0000000 + 32'(i));
    end
    step();
    req(1'b1);
    req(1'b1);
    step();
    rst_n = 1'b0;
    #1;
    reset_checks();
    model.delete();
    exp_pkt = 0;
    step();
    rst_n = 1'b1;
    step();
    reset_checks();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_start(cyc + 1, 16);
      wr(32'hF0000000 + 32'(i));
    end
    step();
    for (int i = 0; i < 4; i++) req(1'b1);
    finish_pkt(1'b0);

    step();
    step();
    check("starts_pending", 32'(start_q.size()), 32'h0);
    check("words_pending",  32'(data_q.size()),  32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
